mux_lane_pipe: RTL and testbench
================================

MUX_LANE_PIPE -- requirements
Module: mux_lane_pipe

Interface
REQ-001 Parameter LANE_W, default 4: width of one lane in bits.
REQ-002 Parameter LANES, default 8: number of lanes in the input word; legal range 2..64.
REQ-003 Parameter SEL_W, default 3: select width, equal to ceil(log2(LANES)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  input word and controls valid.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 in_data  input  LANES*LANE_W  packed lanes; lane k = in_data[k*LANE_W +: LANE_W].
REQ-009 in_sel  input  SEL_W  lane index for single-select mode.
REQ-010 in_scan  input  1  1 = scan mode (emit all lanes), 0 = single-select.
REQ-011 out_valid  output  1  output beat valid.
REQ-012 out_ready  input  1  downstream accepts beat.
REQ-013 out_data  output  LANE_W  selected lane.
REQ-014 out_last  output  1  final beat of the transaction.
REQ-015 out_err  output  1  selected index >= LANES.

Function
REQ-016 Transfer: in handshake when in_valid & in_ready; out handshake when out_valid & out_ready.
REQ-017 FSM states: IDLE (out_valid=0), ONE (holding single beat), SCAN (emitting lanes).
REQ-018 in_ready = (state==IDLE) | (state==ONE & out_ready); 0 in SCAN.
REQ-019 IDLE + in handshake, in_scan=0: capture lane in_sel into out_data, go ONE next cycle; latency 1 cycle.
REQ-020 IDLE + in handshake, in_scan=1: capture full in_data into word buffer, lane counter=0, go SCAN.
REQ-021 ONE: out_last=1; on out handshake with simultaneous in handshake, load new transaction (ONE or SCAN) same edge, no bubble; out handshake alone -> IDLE.
REQ-022 SCAN: out_data = buffered lane[counter]; on out handshake counter increments; out_last=1 when counter==LANES-1; handshake on last beat -> IDLE, counter -> 0.
REQ-023 Without out_ready, out_valid, out_data, out_last, out_err hold stable (no change while stalled).
REQ-024 in_sel >= LANES: out_data=0, out_err=1 for that beat; otherwise out_err=0; scan beats never set out_err.
REQ-025 All outputs driven from registers or combinational only from registered state and out_ready (in_ready only); no in_data-to-out_data combinational path.
REQ-026 Lane ordering distinct and exhaustive: every index 0..LANES-1 maps to its own lane; no duplicated select decode.

Reset
REQ-027 rst_n=0 at a rising edge: state IDLE, counter 0, out_valid 0, out_data 0, out_last 0, out_err 0, word buffer 0.
REQ-028 in_ready reads 1 the cycle after reset deasserts.
REQ-029 Reset mid-SCAN or mid-ONE abandons the transaction; no remaining beats emitted after reset.

Configuration
REQ-030 Macro MUX_LANE_PIPE_SCAN_EN defined: scan mode, word buffer, lane counter and SCAN state compiled in per REQ-020/022.
REQ-031 Macro undefined: in_scan ignored (treated as 0), no word buffer or counter, FSM IDLE/ONE only, out_last tied 1 whenever out_valid=1.

Verification
REQ-032 LANES=8, LANE_W=4, in_data=32'h87654321, in_sel=5, in_scan=0, out_ready=1 -> next cycle out_valid=1, out_data=4'h6, out_last=1, out_err=0.
REQ-033 Same word, in_scan=1 (SCAN_EN defined), out_ready=1 -> 8 beats out_data 1,2,...,8; out_last only on beat 8; in_ready 0 throughout SCAN.
REQ-034 Scan with out_ready toggling 1,0,1,0 -> each lane emitted exactly once, out_data stable during stall cycles, no lane skipped.
REQ-035 Back-to-back singles in_sel=0 then 7, out_ready=1 constantly -> out_data 1 then 8 on consecutive cycles, out_valid never drops.
REQ-036 LANES=6 instance, in_sel=6 -> out_data=0, out_err=1; rst_n=0 asserted during third scan beat -> next cycle out_valid=0, state IDLE, in_ready=1 after release.

Source files
------------

// File: rtl/mux_lane_pipe.sv
// mux_lane_pipe -- lane select / lane scan output stage.
//
// Picks one LANE_W-bit lane out of a packed LANES-lane input word and emits
// it as a single registered beat, or (scan build) buffers the whole word and
// emits every lane in order 0..LANES-1 as a multi-beat transaction.
//
// Build option: define MUX_LANE_PIPE_SCAN_EN to compile in scan mode (word
// buffer, lane counter, SCAN state). Without it in_scan is ignored and every
// transaction is a single beat with out_last=1.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake for in_data/in_sel/in_scan
//   in_data             packed lanes, lane k = in_data[k*LANE_W +: LANE_W]
//   in_sel              lane index for single-select mode
//   in_scan             1 = emit all lanes, 0 = emit lane in_sel
//   out_valid/out_ready output beat handshake
//   out_data            emitted lane
//   out_last            final beat of the transaction
//   out_err             single-select index was out of range (data forced 0)
module mux_lane_pipe #(
  parameter int LANE_W = 4,
  parameter int LANES  = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_scan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W-1:0]       out_data,
  output logic                    out_last,
  output logic                    out_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ONE  = 2'd1;
`ifdef MUX_LANE_PIPE_SCAN_EN
  localparam logic [1:0] S_SCAN = 2'd2;
`endif
  localparam logic [SEL_W:0] LANES_C = (SEL_W+1)'(LANES);

  logic [1:0]        state_q, state_d;
  logic [LANE_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              in_hs, out_hs;

  // Unpack the input word once; each index owns exactly one lane.
  logic [LANE_W-1:0] lane [LANES];
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane[k] = in_data[k*LANE_W +: LANE_W];
  end

  // Out-of-range selects match no lane, so sel_lane falls back to 0.
  logic [LANE_W-1:0] sel_lane;
  logic              sel_err;
  assign sel_err = {1'b0, in_sel} >= LANES_C;
  always_comb begin
    sel_lane = '0;
    for (int k = 0; k < LANES; k++)
      if (in_sel == SEL_W'(k)) sel_lane = lane[k];
  end

`ifdef MUX_LANE_PIPE_SCAN_EN
  logic [SEL_W-1:0]  cnt_q, cnt_d;
  logic [LANE_W-1:0] wbuf_q [LANES];
  logic [LANE_W-1:0] wbuf_d [LANES];
  logic              cnt_last;
  assign cnt_last = (cnt_q == SEL_W'(LANES-1));
`else
  logic unused_scan;
  assign unused_scan = in_scan;
`endif

  // in_ready depends only on state and out_ready: ONE can take a new
  // transaction on the same edge its beat drains.
  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_ONE) & out_ready);
  assign out_valid = (state_q != S_IDLE);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign out_err   = err_q & (state_q == S_ONE);

`ifdef MUX_LANE_PIPE_SCAN_EN
  assign out_data = (state_q == S_SCAN) ? wbuf_q[cnt_q] : data_q;
  assign out_last = (state_q == S_ONE) | ((state_q == S_SCAN) & cnt_last);
`else
  assign out_data = data_q;
  assign out_last = out_valid;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef MUX_LANE_PIPE_SCAN_EN
    cnt_d   = cnt_q;
    wbuf_d  = wbuf_q;
`endif
    // in_hs only happens in IDLE, or in ONE together with out_hs, so a new
    // load always supersedes the drain of the current single beat.
    if (in_hs) begin
`ifdef MUX_LANE_PIPE_SCAN_EN
      if (in_scan) begin
        wbuf_d  = lane;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_SCAN;
      end else
`endif
      begin
        data_d  = sel_lane;
        err_d   = sel_err;
        state_d = S_ONE;
      end
    end else if (out_hs) begin
`ifdef MUX_LANE_PIPE_SCAN_EN
      if (state_q == S_SCAN) begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else
`endif
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef MUX_LANE_PIPE_SCAN_EN
      cnt_q   <= '0;
      for (int k = 0; k < LANES; k++) wbuf_q[k] <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef MUX_LANE_PIPE_SCAN_EN
      cnt_q   <= cnt_d;
      wbuf_q  <= wbuf_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux_lane_pipe.sv
module tb_mux_lane_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-lane instance
  logic        rst8_n, iv8, ir8, sc8, ov8, or8, ol8, oe8;
  logic [31:0] id8;
  logic [2:0]  is8;
  logic [3:0]  od8;
  // 6-lane instance
  logic        rst6_n, iv6, ir6, sc6, ov6, or6, ol6, oe6;
  logic [23:0] id6;
  logic [2:0]  is6;
  logic [3:0]  od6;

  int ncmp = 0;
  int nfail = 0;

  mux_lane_pipe #(.LANE_W(4), .LANES(8), .SEL_W(3)) u8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .in_sel(is8), .in_scan(sc8), .out_valid(ov8), .out_ready(or8),
    .out_data(od8), .out_last(ol8), .out_err(oe8));

  mux_lane_pipe #(.LANE_W(4), .LANES(6), .SEL_W(3)) u6 (
    .clk(clk), .rst_n(rst6_n), .in_valid(iv6), .in_ready(ir6), .in_data(id6),
    .in_sel(is6), .in_scan(sc6), .out_valid(ov6), .out_ready(or6),
    .out_data(od6), .out_last(ol6), .out_err(oe6));

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst8_n = 0; iv8 = 0; id8 = 32'h87654321; is8 = 0; sc8 = 0; or8 = 1;
    rst6_n = 0; iv6 = 0; id6 = 24'h654321;   is6 = 0; sc6 = 0; or6 = 1;
    @(negedge clk);
    step();

    // reset state
    ck("rst_valid8", ov8, 0);
    ck("rst_data8",  od8, 0);
    ck("rst_last8",  ol8, 0);
    ck("rst_err8",   oe8, 0);
    ck("rst_valid6", ov6, 0);
    ck("rst_data6",  od6, 0);
    rst8_n = 1; rst6_n = 1;
    step();
    ck("rdy_after_rst8", ir8, 1);
    ck("rdy_after_rst6", ir6, 1);

    // single select lane 5 -> 6
    iv8 = 1; is8 = 5; sc8 = 0;
    step();
    iv8 = 0;
    ck("one_valid", ov8, 1);
    ck("one_data",  od8, 4'h6);
    ck("one_last",  ol8, 1);
    ck("one_err",   oe8, 0);
    step();
    ck("one_drain", ov8, 0);

    // back-to-back singles lane 0 then 7
    iv8 = 1; is8 = 0;
    step();
    ck("b2b_valid0", ov8, 1);
    ck("b2b_data0",  od8, 4'h1);
    ck("b2b_rdy",    ir8, 1);
    is8 = 7;
    step();
    iv8 = 0;
    ck("b2b_valid1", ov8, 1);
    ck("b2b_data1",  od8, 4'h8);
    ck("b2b_err1",   oe8, 0);
    step();
    ck("b2b_drain", ov8, 0);

    // stalled single beat holds; new input is refused
    iv8 = 1; is8 = 2; or8 = 0;
    step();
    is8 = 3;
    ck("stall_data0", od8, 4'h3);
    ck("stall_rdy",   ir8, 0);
    step();
    ck("stall_valid1", ov8, 1);
    ck("stall_data1",  od8, 4'h3);
    ck("stall_last1",  ol8, 1);
    iv8 = 0; or8 = 1;
    step();
    ck("stall_drain", ov8, 0);

    // 6-lane: out-of-range and in-range select
    iv6 = 1; is6 = 6;
    step();
    is6 = 5;
    ck("oor_valid", ov6, 1);
    ck("oor_data",  od6, 0);
    ck("oor_err",   oe6, 1);
    step();
    iv6 = 0;
    ck("top6_data", od6, 4'h6);
    ck("top6_err",  oe6, 0);
    step();
    ck("six_drain", ov6, 0);

`ifdef MUX_LANE_PIPE_SCAN_EN
    // full-speed scan: lanes 1..8, last on beat 8 only
    iv8 = 1; sc8 = 1; or8 = 1;
    step();
    iv8 = 0; sc8 = 0;
    for (int k = 0; k < 8; k++) begin
      ck("scan_valid", ov8, 1);
      ck("scan_data",  od8, k + 1);
      ck("scan_last",  ol8, (k == 7));
      ck("scan_rdy",   ir8, 0);
      ck("scan_err",   oe8, 0);
      step();
    end
    ck("scan_drain", ov8, 0);
    ck("scan_rdy_end", ir8, 1);

    // scan with out_ready toggling: every lane once, held while stalled
    begin
      int e;
      e = 0;
      iv8 = 1; sc8 = 1; or8 = 1;
      step();
      iv8 = 0; sc8 = 0;
      for (int c = 0; c < 40 && e < 8; c++) begin
        or8 = (c % 2 == 0);
        ck("tog_valid", ov8, 1);
        ck("tog_data",  od8, e + 1);
        ck("tog_last",  ol8, (e == 7));
        step();
        if (c % 2 == 0) e++;
      end
      or8 = 1;
      ck("tog_drain", ov8, 0);
    end

    // 6-lane scan, reset during third beat
    iv6 = 1; sc6 = 1; or6 = 1;
    step();
    iv6 = 0; sc6 = 0;
    ck("rs_beat1", od6, 4'h1);
    step();
    ck("rs_beat2", od6, 4'h2);
    step();
    ck("rs_beat3", od6, 4'h3);
    rst6_n = 0;
    step();
    ck("rs_valid", ov6, 0);
    ck("rs_data",  od6, 0);
    rst6_n = 1;
    step();
    ck("rs_after_valid", ov6, 0);
    ck("rs_after_rdy",   ir6, 1);
    step();
    ck("rs_no_beats", ov6, 0);
`else
    // in_scan ignored: behaves as single select
    iv8 = 1; sc8 = 1; is8 = 5; or8 = 1;
    step();
    iv8 = 0; sc8 = 0;
    ck("noscan_data", od8, 4'h6);
    ck("noscan_last", ol8, 1);
    step();
    ck("noscan_drain", ov8, 0);

    // 6-lane stalled single beat, reset abandons it
    iv6 = 1; is6 = 1; or6 = 0;
    step();
    iv6 = 0;
    ck("rs_held_valid", ov6, 1);
    ck("rs_held_data",  od6, 4'h2);
    rst6_n = 0;
    step();
    ck("rs_valid", ov6, 0);
    ck("rs_data",  od6, 0);
    rst6_n = 1; or6 = 1;
    step();
    ck("rs_after_valid", ov6, 0);
    ck("rs_after_rdy",   ir6, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
